// File: rtl/vector_pkg.sv
// Shared encodings for the vector op sequencer: ALU op codes, FSM state type
// and the default lane count.
package vector_pkg;

  localparam int NUM_LANES_DEFAULT = 8;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MOV  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_DIV  = 3'b100;
  localparam logic [2:0] ALU_CMP  = 3'b101;
  localparam logic [2:0] ALU_NODP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_DIV = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/seq_elem_counter.sv
// Element index counter: load clears the index and captures the vector length;
// last flags the final element so the sequencer never steps past vlen-1.
module seq_elem_counter #(
  parameter int NUM_LANES = 8,
  parameter int IDXW      = $clog2(NUM_LANES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [IDXW:0]   vlen,
  input  logic            inc,
  output logic [IDXW-1:0] idx,
  output logic            last
);

  logic [IDXW-1:0] idx_q;
  logic [IDXW:0]   len_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      len_q <= '0;
    end else if (load) begin
      idx_q <= '0;
      len_q <= vlen;
    end else if (inc && !last) begin
      idx_q <= idx_q + IDXW'(1);
    end
  end

  // A zero length wraps to all ones, which never matches a zero-extended index.
  assign last = ({1'b0, idx_q} == (len_q - (IDXW + 1)'(1)));
  assign idx  = idx_q;

endmodule

// File: rtl/vector_op_sequencer.sv
// Issues one ALU op across up to NUM_LANES elements, one element per cycle,
// waiting on the divider for DIV and folding lane zero flags for CMP.
module vector_op_sequencer
  import vector_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEFAULT,
  parameter int IDXW      = $clog2(NUM_LANES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      ALUControl,
  input  logic [IDXW:0]   vlen,
  input  logic            elem_zero,
  input  logic            div_done,
  output logic [IDXW-1:0] elem_idx,
  output logic            alu_valid,
  output logic            elem_we,
  output logic            stall,
  output logic            done,
  output logic            zero_all,
  output logic [1:0]      dbg_state
);

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic       acc_q;
  logic       accept_run;
  logic       complete;
  logic       last;
  logic       is_div;
  logic       is_cmp;

  assign is_div     = (op_q == ALU_DIV);
  assign is_cmp     = (op_q == ALU_CMP);
  assign accept_run = (state_q == ST_IDLE) && start &&
                      (ALUControl != ALU_NODP) && (vlen != '0);
  assign complete   = ((state_q == ST_RUN) && !is_div) ||
                      ((state_q == ST_WAIT_DIV) && div_done);

  seq_elem_counter #(
    .NUM_LANES (NUM_LANES),
    .IDXW      (IDXW)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (accept_run),
    .vlen  (vlen),
    .inc   (complete),
    .idx   (elem_idx),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_run)  state_d = ST_RUN;
        else if (start)  state_d = ST_DONE;
      end
      ST_RUN: begin
        if (is_div)        state_d = ST_WAIT_DIV;
        else if (last)     state_d = ST_DONE;
      end
      ST_WAIT_DIV: begin
        if (div_done)      state_d = last ? ST_DONE : ST_RUN;
      end
      default:             state_d = ST_IDLE;
    endcase
  end

  // A no-issue accept latches NODP so its DONE cannot disturb zero_all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= ALU_NODP;
      acc_q    <= 1'b1;
      zero_all <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start)
        op_q <= accept_run ? ALUControl : ALU_NODP;
      if (accept_run)
        acc_q <= 1'b1;
      else if (complete && is_cmp)
        acc_q <= acc_q & elem_zero;
      if ((state_q == ST_DONE) && is_cmp)
        zero_all <= acc_q;
    end
  end

  assign alu_valid = (state_q == ST_RUN) || (state_q == ST_WAIT_DIV);
  assign stall     = alu_valid;
  assign done      = (state_q == ST_DONE);
  assign elem_we   = ((state_q == ST_RUN) && !is_div && !is_cmp) ||
                     ((state_q == ST_WAIT_DIV) && div_done);
  assign dbg_state = state_q;

endmodule

// File: doc/vector_op_sequencer.md
VECTOR_OP_SEQUENCER -- requirements
Module: vector_op_sequencer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 8, giving the maximum elements per vector op (power of two).
REQ-002 SHALL have parameter IDXW, default $clog2(NUM_LANES), giving the element index width.
REQ-003 clk  in  1  single rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to run one vector op; sampled only in IDLE.
REQ-006 ALUControl  in  3  op code from the ALU decoder: 000 ADD, 001 SUB, 010 MOV, 011 MUL, 100 DIV, 101 CMP, 111 non-DP.
REQ-007 vlen  in  IDXW+1  element count, 0..NUM_LANES.
REQ-008 elem_zero  in  1  lane result-zero flag for the element currently issued.
REQ-009 div_done  in  1  multi-cycle divider result-valid strobe.
REQ-010 elem_idx  out  IDXW  index of the element currently issued.
REQ-011 alu_valid  out  1  lane operands valid / op issued.
REQ-012 elem_we  out  1  element write-back enable.
REQ-013 stall  out  1  freeze fetch/decode while the sequencer is busy.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 zero_all  out  1  AND of elem_zero over all elements of the last CMP.

Function
REQ-016 SHALL implement the states IDLE, RUN, WAIT_DIV and DONE.
REQ-017 IDLE, start=1, op not 111, vlen greater than 0: latch op and vlen, clear the index to 0, preset the zero accumulator to 1, and go to RUN.
REQ-018 IDLE, start=1, op 111 or vlen=0: go to DONE with no issue and no write; zero_all unchanged.
REQ-019 start SHALL be ignored in every state other than IDLE, and the latched op and vlen SHALL NOT change until the next accept.
REQ-020 RUN, non-DIV op: alu_valid=1, elem_idx=index; elem_we=1 except for CMP (elem_we=0).
REQ-021 RUN, non-DIV op: each cycle completes one element.
REQ-022 RUN, DIV op: alu_valid=1, elem_we=0, go to WAIT_DIV.
REQ-023 WAIT_DIV: hold alu_valid=1 and elem_idx stable.
REQ-024 WAIT_DIV, on div_done=1: elem_we=1 in that cycle, and the element completes.
REQ-025 WAIT_DIV: wait indefinitely if div_done never arrives.
REQ-026 Element completion: for CMP, accumulator = accumulator AND elem_zero.
REQ-027 Element completion: if index = vlen-1, go to DONE; otherwise increment the index and go to (or stay in) RUN.
REQ-028 The index SHALL never exceed vlen-1 and SHALL never wrap.
REQ-029 div_done asserted outside WAIT_DIV SHALL be ignored.
REQ-030 DONE: done=1 for exactly one cycle; zero_all loads the accumulator if the op was CMP; return to IDLE.
REQ-031 A start in the DONE cycle SHALL be ignored; a start is accepted no earlier than the following IDLE cycle.
REQ-032 stall = 1 in RUN and WAIT_DIV, and 0 in IDLE and DONE.
REQ-033 alu_valid, elem_we and done SHALL be 0 in any state where they are not specified above.
REQ-034 Non-DIV latency: accept at edge T; RUN for L cycles; done high in cycle T+L+1.
REQ-035 DIV latency: each element costs 1 cycle plus the wait for div_done.

Reset
REQ-036 reset=1 SHALL immediately force state IDLE, index 0, accumulator 1, and zero_all 0.
REQ-037 reset=1 SHALL immediately force alu_valid, elem_we, stall and done to 0.
REQ-038 Reset mid-operation SHALL abandon the op with no further writes and no done pulse.
REQ-039 After reset deassertion, the first start SHALL be accepted on the next rising edge.

Structure
REQ-040 Shared package vector_pkg SHALL hold the ALUControl encodings (ALU_ADD … ALU_NODP), the state enum, and the NUM_LANES default.
REQ-041 One sub-module, seq_elem_counter, SHALL provide the loadable/clearable index counter with last = (index == vlen-1).
REQ-042 The FSM and accumulator SHALL stay in the top module.

Verification
REQ-043 ADD, vlen=4, start pulse: elem_we high 4 consecutive cycles with elem_idx 0,1,2,3; stall high 4 cycles; done in cycle 5.
REQ-044 CMP, vlen=3, elem_zero=1,1,0: elem_we never high; zero_all=0 after done. Repeat with 1,1,1: zero_all=1.
REQ-045 DIV, vlen=2, div_done after 3 and 5 wait cycles: elem_idx holds at 0 then 1; exactly 2 elem_we pulses coincide with div_done; done one cycle after the second.
REQ-046 start with ALUControl=111, and separately ADD with vlen=0: done one cycle later; no alu_valid; stall stays 0.
REQ-047 MUL, vlen=8, reset asserted at element 4 for 1 cycle: outputs drop to 0 asynchronously; no done; a new SUB, vlen=1, then completes normally.
REQ-048 start held high through a whole ADD, vlen=2, run: only one op runs; the second accept occurs in the IDLE cycle after done.
